// File: rtl/dsp_pkg.sv
// Shared definitions for the interconnect dispatcher: AXI4 length width,
// default outstanding depth and the read-order queue entry.
package dsp_pkg;

    localparam int AXI_LEN_W           = 8;
    localparam int DEFAULT_OUTST_DEPTH = 4;
    // Widest slave index a dispatcher may use; narrower ids are zero-extended.
    localparam int MAX_SLV_ID_W        = 8;

    typedef struct packed {
        logic [MAX_SLV_ID_W-1:0] slv_id;
        logic [AXI_LEN_W-1:0]    len;
    } order_entry_t;

    function automatic order_entry_t make_entry(input logic [MAX_SLV_ID_W-1:0] slv_id,
                                                input logic [AXI_LEN_W-1:0]    len);
        order_entry_t e;
        e.slv_id = slv_id;
        e.len    = len;
        return e;
    endfunction

endpackage

// File: rtl/dsp_order_fifo.sv
// Circular order queue with registered pointers/count and a combinational
// head read, so a freshly pushed entry is visible the cycle after the push.
module dsp_order_fifo
    import dsp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_OUTST_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  order_entry_t     wdata,
    input  logic             pop,
    output order_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    order_entry_t    mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage carries no reset; stale slots are never read while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // DEPTH is a power of two, so plain increment wraps the index and toggles the wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsp_rdata_order_ctrl.sv
// Read-side ordering controller: queues accepted ARs in arrival order and
// steers the RDATA dispatcher to the head burst until its last beat retires it.
module dsp_rdata_order_ctrl
    import dsp_pkg::*;
#(
    parameter int SLV_AMT     = 2,
    parameter int SLV_ID_W    = $clog2(SLV_AMT),
    parameter int LEN_W       = AXI_LEN_W,
    parameter int OUTST_DEPTH = DEFAULT_OUTST_DEPTH,
    parameter int OUTST_CNT_W = $clog2(OUTST_DEPTH + 1)
) (
    input  logic                   ACLK_i,
    input  logic                   ARESET_i,
    input  logic                   m_ARVALID_i,
    input  logic [LEN_W-1:0]       m_ARLEN_i,
    input  logic [SLV_ID_W-1:0]    dec_AR_slv_id_i,
    input  logic                   s_ARREADY_i,
    output logic                   m_ARREADY_o,
    output logic                   s_ARVALID_o,
    input  logic                   dsp_R_handshake_occur_i,
    input  logic                   m_RLAST_i,
    output logic [SLV_ID_W-1:0]    dsp_AR_slv_id_o,
    output logic                   dsp_AR_disable_o,
    output logic [OUTST_CNT_W-1:0] outst_cnt_o,
    output logic                   rlast_err_o
);

    order_entry_t         push_entry;
    order_entry_t         head;
    logic                 q_full;
    logic                 q_empty;
    logic                 ar_push;
    logic                 r_valid_hs;
    logic                 last_beat;
    logic                 head_pop;
    logic [LEN_W-1:0]     beat_cnt;

    // Throttling uses the registered full flag: a pop frees a slot only from the next cycle.
    assign m_ARREADY_o = s_ARREADY_i & ~q_full;
    assign s_ARVALID_o = m_ARVALID_i & ~q_full;
    assign ar_push     = m_ARVALID_i & m_ARREADY_o;
    assign push_entry  = make_entry(MAX_SLV_ID_W'(dec_AR_slv_id_i), AXI_LEN_W'(m_ARLEN_i));

    dsp_order_fifo #(
        .DEPTH (OUTST_DEPTH),
        .CNT_W (OUTST_CNT_W)
    ) u_order_fifo (
        .clk   (ACLK_i),
        .rst   (ARESET_i),
        .push  (ar_push),
        .wdata (push_entry),
        .pop   (head_pop),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (outst_cnt_o)
    );

    // A beat arriving with nothing outstanding is dropped and only flagged.
    assign r_valid_hs = dsp_R_handshake_occur_i & ~q_empty;
    assign last_beat  = (AXI_LEN_W'(beat_cnt) == head.len);
    assign head_pop   = r_valid_hs & last_beat;

    assign dsp_AR_slv_id_o  = q_empty ? '0 : SLV_ID_W'(head.slv_id);
    assign dsp_AR_disable_o = q_empty;

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            beat_cnt <= '0;
        end else if (r_valid_hs) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // Retirement follows the beat counter; RLAST is only cross-checked against it.
    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            rlast_err_o <= 1'b0;
        end else if (dsp_R_handshake_occur_i &&
                     (q_empty || (m_RLAST_i != last_beat))) begin
            rlast_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsp_rdata_order_ctrl.sv
// Directed bench for dsp_rdata_order_ctrl: ordering, throttling, wrap,
// RLAST error flagging and mid-burst reset, with hand-computed expectations.
module tb_dsp_rdata_order_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ar_valid;
    logic [7:0] ar_len;
    logic       ar_id;
    logic       s_ar_ready;
    logic       m_ar_ready;
    logic       s_ar_valid;
    logic       r_hs;
    logic       r_last;
    logic       slv_id;
    logic       disable_r;
    logic [2:0] outst_cnt;
    logic       rlast_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsp_rdata_order_ctrl #(
        .SLV_AMT     (2),
        .OUTST_DEPTH (4)
    ) dut (
        .ACLK_i                  (clk),
        .ARESET_i                (rst),
        .m_ARVALID_i             (ar_valid),
        .m_ARLEN_i               (ar_len),
        .dec_AR_slv_id_i         (ar_id),
        .s_ARREADY_i             (s_ar_ready),
        .m_ARREADY_o             (m_ar_ready),
        .s_ARVALID_o             (s_ar_valid),
        .dsp_R_handshake_occur_i (r_hs),
        .m_RLAST_i               (r_last),
        .dsp_AR_slv_id_o         (slv_id),
        .dsp_AR_disable_o        (disable_r),
        .outst_cnt_o             (outst_cnt),
        .rlast_err_o             (rlast_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let inputs be redriven away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ar_valid   = 1'b0;
        ar_len     = 8'd0;
        ar_id      = 1'b0;
        s_ar_ready = 1'b1;
        r_hs       = 1'b0;
        r_last     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_ar(input logic id, input logic [7:0] len);
        ar_valid = 1'b1;
        ar_id    = id;
        ar_len   = len;
        step();
        ar_valid = 1'b0;
    endtask

    task automatic r_beat(input logic last);
        r_hs   = 1'b1;
        r_last = last;
        step();
        r_hs   = 1'b0;
        r_last = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_disable"}, disable_r, 1'b1);
        check({tag, "_slv"}, slv_id, 1'b0);
        check({tag, "_cnt"}, outst_cnt, 3'd0);
    endtask

    logic exp_order [4];

    initial begin
        do_reset();

        // Reset and idle
        check_idle("rst");
        check("rst_err", rlast_err, 1'b0);
        check("rst_arready", m_ar_ready, 1'b1);
        check("rst_arvalid_lo", s_ar_valid, 1'b0);
        s_ar_ready = 1'b0;
        ar_valid   = 1'b1;
        #1;
        check("rst_arready_lo", m_ar_ready, 1'b0);
        check("rst_arvalid", s_ar_valid, 1'b1);
        idle_inputs();

        // Single burst to slave 1, four beats
        push_ar(1'b1, 8'd3);
        #1;
        check("b1_slv", slv_id, 1'b1);
        check("b1_disable", disable_r, 1'b0);
        check("b1_cnt", outst_cnt, 3'd1);
        for (int i = 0; i < 3; i++) r_beat(1'b0);
        #1;
        check("b1_cnt_3beats", outst_cnt, 3'd1);
        check("b1_slv_3beats", slv_id, 1'b1);
        r_beat(1'b1);
        check_idle("b1_done");
        check("b1_err", rlast_err, 1'b0);

        // Fill to OUTST_DEPTH and verify throttling and retirement order
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) push_ar(exp_order[i], 8'd0);
        ar_valid = 1'b1;
        ar_id    = 1'b1;
        #1;
        check("full_cnt", outst_cnt, 3'd4);
        check("full_arready", m_ar_ready, 1'b0);
        check("full_arvalid", s_ar_valid, 1'b0);
        check("full_head", slv_id, exp_order[0]);
        r_hs   = 1'b1;
        r_last = 1'b1;
        #1;
        check("full_pop_arready", m_ar_ready, 1'b0);
        step();
        r_hs     = 1'b0;
        r_last   = 1'b0;
        ar_valid = 1'b0;
        #1;
        check("after_pop_cnt", outst_cnt, 3'd3);
        check("after_pop_arready", m_ar_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("order_%0d", i), slv_id, exp_order[i]);
            r_beat(1'b1);
        end
        check_idle("order_done");

        // Simultaneous push and last-beat pop at count 2 (pointers wrap here)
        push_ar(1'b0, 8'd1);
        push_ar(1'b1, 8'd0);
        r_beat(1'b0);
        ar_valid = 1'b1;
        ar_id    = 1'b0;
        ar_len   = 8'd0;
        r_hs     = 1'b1;
        r_last   = 1'b1;
        step();
        idle_inputs();
        #1;
        check("pp_cnt", outst_cnt, 3'd2);
        check("pp_head", slv_id, 1'b1);
        r_beat(1'b1);
        #1;
        check("pp_head2", slv_id, 1'b0);
        check("pp_cnt2", outst_cnt, 3'd1);
        r_beat(1'b1);
        check_idle("pp_done");
        check("pp_err", rlast_err, 1'b0);

        // Early RLAST on a two-beat burst
        push_ar(1'b1, 8'd1);
        r_beat(1'b1);
        #1;
        check("early_err", rlast_err, 1'b1);
        check("early_cnt", outst_cnt, 3'd1);
        r_beat(1'b1);
        check_idle("early_done");
        check("early_err_sticky", rlast_err, 1'b1);

        // Reset mid-burst clears queue, beat count and error flag
        do_reset();
        #1;
        check("rst2_err", rlast_err, 1'b0);
        push_ar(1'b1, 8'd3);
        push_ar(1'b0, 8'd0);
        r_beat(1'b0);
        #1;
        check("mid_cnt", outst_cnt, 3'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_rst");
        check("mid_rst_err", rlast_err, 1'b0);
        push_ar(1'b1, 8'd0);
        r_beat(1'b1);
        check_idle("mid_post");
        check("mid_post_err", rlast_err, 1'b0);

        // Handshake with nothing outstanding is ignored but flagged
        r_beat(1'b1);
        check_idle("empty_hs");
        check("empty_hs_err", rlast_err, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
